traffic_light_fsm: RTL and testbench
====================================

Name: traffic_light_fsm

Overview:
Sequencing controller for the intersection. It drives the main-street and side-street lamp heads and the pedestrian walk lamp. It runs the countdown timer through a start/select/expired handshake: the controller selects which programmed interval (base, extension, yellow) the timer loads, pulses its start, and advances state when the timer reports expiry. The controller sits between the synchronised sensor/button inputs and the timer/lamp outputs.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchroniser on sensor and walk_request (legal values 2..3)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
sensor  in  1  side-street vehicle present; asynchronous, synchronised internally
walk_request  in  1  pedestrian button; asynchronous level, synchronised internally
expired  in  1  one-cycle pulse from the timer: the selected interval has elapsed
start_timer  out  1  one-cycle pulse to the timer: load the interval given by interval_sel
interval_sel  out  2  00 = base, 01 = extension, 10 = yellow; 11 never driven
main_lights  out  3  {red, yellow, green}, one-hot
side_lights  out  3  {red, yellow, green}, one-hot
walk_lamp  out  1  pedestrian walk indication
state_dbg  out  3  encoded current state, for the display/debug

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, and all state is reset by it.
- All outputs are registered. Reset values:
  - state = MAIN_G1, interval_sel = 00, start_timer = 1
  - main_lights = 001, side_lights = 100, walk_lamp = 0
  - walk_pending = 0, synchroniser flops = 0
- start_timer is held at 1 through reset. It stays high for exactly the first cycle after reset deasserts, which restarts the timer with the base interval.
- States (encoding 0..7), lamp outputs, interval loaded on entry:
  - MAIN_G1: main G, side R; base
  - MAIN_G2: main G, side R; base
  - MAIN_GX: main G, side R; extension
  - MAIN_Y: main Y, side R; yellow
  - WALK: both R, walk_lamp = 1; extension
  - SIDE_G: main R, side G; base
  - SIDE_GX: main R, side G; extension
  - SIDE_Y: main R, side Y; yellow
- Transitions happen only on a qualified expiry (expired = 1 and start_timer = 0):
  - MAIN_G1 -> MAIN_GX if sensor_s, else MAIN_G2
  - MAIN_G2 -> MAIN_Y
  - MAIN_GX -> MAIN_Y
  - MAIN_Y -> WALK if walk_pending, else SIDE_G
  - WALK -> SIDE_G
  - SIDE_G -> SIDE_GX if sensor_s, else SIDE_Y
  - SIDE_GX -> SIDE_Y
  - SIDE_Y -> MAIN_G1
- Handshake timing:
  - A transition taken in cycle N makes the new state, lamps and interval_sel visible in cycle N+1, with start_timer = 1 in cycle N+1 only.
  - interval_sel is stable for the whole state.
  - expired is ignored in any cycle where start_timer = 1.
  - A timer loaded with zero expires the cycle after start. The FSM then spends exactly 2 cycles in that state; no stall and no lockup.
- Sensor sampling: sensor_s (synchronised, SYNC_STAGES flops) is sampled only in the qualified-expiry cycle of MAIN_G1 or SIDE_G. Toggles at any other time have no effect.
- Pedestrian request:
  - walk_pending is set by the synchronised walk_request in any cycle.
  - It is cleared on the transition into WALK.
  - Clear wins over a simultaneous set; that request is served by the walk being entered.
  - A request during WALK, SIDE_G, SIDE_GX or SIDE_Y is served in the next cycle's MAIN_Y -> WALK.
- Lamp safety: main and side are never both non-red. Each lamp vector is always one-hot.
- Reset mid-operation (any state, including mid-yellow) returns to the reset values in the next cycle. The pending walk is discarded.
- Spurious expired while in the hold cycle (start_timer = 1) must not advance the state.

Decomposition:
- Package traffic_pkg:
  - selector constants BASE_SELECT = 2'b00, EXT_SELECT = 2'b01, YEL_SELECT = 2'b10
  - state encoding constants
  - lamp constants LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001
  - The timer block shares the same package.
- One sub-module: sync_bit (SYNC_STAGES-deep flop chain, reset to 0), instantiated twice, for sensor and walk_request.

Test Plan:
- Reset release, sensor = 0, no walk, expiry pulsed 5 cycles after every start:
  - start_timer high 1st cycle after reset with sel 00.
  - Visit order: MAIN_G1, MAIN_G2, MAIN_Y, SIDE_G, SIDE_Y, MAIN_G1.
  - sel sequence: 00, 00, 10, 00, 10, 00.
- sensor = 1 held: sequence MAIN_G1, MAIN_GX (sel 01), MAIN_Y, SIDE_G, SIDE_GX (sel 01), SIDE_Y.
- Sensor pulse timing:
  - Sensor pulses high for 1 cycle mid-MAIN_G1, low at expiry: MAIN_G2 is taken.
  - Sensor high only at the expiry (after sync latency): MAIN_GX is taken.
- Walk request:
  - walk_request pulse during SIDE_Y gives MAIN_G1, MAIN_G2, MAIN_Y, then WALK (both 100, walk_lamp = 1, sel 01), then SIDE_G.
  - A second pulse in the WALK-entry cycle does not cause another WALK.
- Zero interval: expired asserted the cycle right after each start_timer. Each state lasts 2 cycles, and expired coinciding with start_timer is ignored.
- Reset mid-operation:
  - Reset asserted during MAIN_Y with walk_pending = 1: next cycle state = 0, lamps 001/100, start_timer = 1.
  - After release, no WALK occurs in the next cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
//
// Shared definitions for the intersection controller and its countdown
// timer. The timer block imports the same package, so the interval
// selector codes and the state encoding live here and nowhere else.
//
// Contents:
//   BASE_SELECT / EXT_SELECT / YEL_SELECT  interval_sel codes (11 is unused)
//   LAMP_RED / LAMP_YEL / LAMP_GRN         one-hot lamp head codes {R,Y,G}
//   ENC_*                                  3-bit state encoding, 0..7
//   state_t                                controller state enum
//   heads_t                                lamp/walk/interval bundle per state
//   heads_for()                            what a state shows and loads on entry
// ---------------------------------------------------------------------------
package traffic_pkg;

    // Interval selector codes seen by the timer.
    localparam logic [1:0] BASE_SELECT = 2'b00;
    localparam logic [1:0] EXT_SELECT  = 2'b01;
    localparam logic [1:0] YEL_SELECT  = 2'b10;

    // Lamp heads are {red, yellow, green}, exactly one bit set.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // State encoding as shown on the debug display.
    localparam logic [2:0] ENC_MAIN_G1 = 3'd0;
    localparam logic [2:0] ENC_MAIN_G2 = 3'd1;
    localparam logic [2:0] ENC_MAIN_GX = 3'd2;
    localparam logic [2:0] ENC_MAIN_Y  = 3'd3;
    localparam logic [2:0] ENC_WALK    = 3'd4;
    localparam logic [2:0] ENC_SIDE_G  = 3'd5;
    localparam logic [2:0] ENC_SIDE_GX = 3'd6;
    localparam logic [2:0] ENC_SIDE_Y  = 3'd7;

    typedef enum logic [2:0] {
        MAIN_G1 = ENC_MAIN_G1,
        MAIN_G2 = ENC_MAIN_G2,
        MAIN_GX = ENC_MAIN_GX,
        MAIN_Y  = ENC_MAIN_Y,
        WALK    = ENC_WALK,
        SIDE_G  = ENC_SIDE_G,
        SIDE_GX = ENC_SIDE_GX,
        SIDE_Y  = ENC_SIDE_Y
    } state_t;

    // Everything a state drives, gathered so the register update is a
    // single assignment per field on entry.
    typedef struct packed {
        logic [2:0] main_lamp;
        logic [2:0] side_lamp;
        logic       walk;
        logic [1:0] sel;
    } heads_t;

    // Lamp pattern, walk indication and timer interval for a state.
    // The default branch is the all-red, base-interval pattern so an
    // unexpected code can never light two greens.
    function automatic heads_t heads_for(input state_t s);
        heads_t h;
        h.main_lamp = LAMP_RED;
        h.side_lamp = LAMP_RED;
        h.walk      = 1'b0;
        h.sel       = BASE_SELECT;
        case (s)
            MAIN_G1: begin
                h.main_lamp = LAMP_GRN;
                h.sel       = BASE_SELECT;
            end
            MAIN_G2: begin
                h.main_lamp = LAMP_GRN;
                h.sel       = BASE_SELECT;
            end
            MAIN_GX: begin
                h.main_lamp = LAMP_GRN;
                h.sel       = EXT_SELECT;
            end
            MAIN_Y: begin
                h.main_lamp = LAMP_YEL;
                h.sel       = YEL_SELECT;
            end
            WALK: begin
                h.walk      = 1'b1;
                h.sel       = EXT_SELECT;
            end
            SIDE_G: begin
                h.side_lamp = LAMP_GRN;
                h.sel       = BASE_SELECT;
            end
            SIDE_GX: begin
                h.side_lamp = LAMP_GRN;
                h.sel       = EXT_SELECT;
            end
            SIDE_Y: begin
                h.side_lamp = LAMP_YEL;
                h.sel       = YEL_SELECT;
            end
            default: begin
                h.main_lamp = LAMP_RED;
                h.side_lamp = LAMP_RED;
            end
        endcase
        return h;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
//
// Single-bit synchroniser: a SYNC_STAGES-deep flop chain bringing an
// asynchronous level into the clk domain. The output follows the input
// SYNC_STAGES rising edges later. All flops clear on reset so a button
// or loop detector held during reset is not seen until it has crossed
// the full chain again.
//
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous, active-high reset
//   d      in  1  asynchronous input level
//   q      out 1  synchronised level
//
// Parameters:
//   SYNC_STAGES  chain depth, 2 or 3
// ---------------------------------------------------------------------------
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// traffic_light_fsm
//
// Sequencing controller for the intersection. Drives the main and side
// lamp heads and the pedestrian walk lamp, and runs the countdown timer:
// on entering a state it selects the interval the timer must load and
// pulses start_timer for one cycle; it leaves the state when the timer
// reports expiry.
//
// Timer handshake (valid/ready style, one rule for both directions):
//   start_timer is a one-cycle command, high exactly in the first cycle of
//   every state, with interval_sel already valid and held for the whole
//   state. expired is only accepted in cycles where start_timer is low;
//   an expiry seen during the start cycle belongs to the previous load
//   and is dropped.
//
// Ports:
//   clk           in  1  system clock
//   reset         in  1  synchronous, active-high reset
//   sensor        in  1  side-street vehicle present (asynchronous)
//   walk_request  in  1  pedestrian button (asynchronous level)
//   expired       in  1  timer interval elapsed, one-cycle pulse
//   start_timer   out 1  load interval_sel into the timer, one-cycle pulse
//   interval_sel  out 2  00 base, 01 extension, 10 yellow
//   main_lights   out 3  main head {red, yellow, green}, one-hot
//   side_lights   out 3  side head {red, yellow, green}, one-hot
//   walk_lamp     out 1  pedestrian walk indication
//   state_dbg     out 3  encoded current state
//
// Parameters:
//   SYNC_STAGES   synchroniser depth for sensor and walk_request (2..3)
// ---------------------------------------------------------------------------
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       expired,
    output logic       start_timer,
    output logic [1:0] interval_sel,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_lamp,
    output logic [2:0] state_dbg
);

    // -----------------------------------------------------------------
    // Input synchronisers
    // -----------------------------------------------------------------
    logic sensor_s;
    logic walk_s;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sensor (
        .clk   (clk),
        .reset (reset),
        .d     (sensor),
        .q     (sensor_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_walk (
        .clk   (clk),
        .reset (reset),
        .d     (walk_request),
        .q     (walk_s)
    );

    // -----------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------
    state_t     state_q;
    logic       start_q;
    logic [1:0] sel_q;
    logic [2:0] main_q;
    logic [2:0] side_q;
    logic       walk_lamp_q;
    logic       walk_pending_q;

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    logic   qual_expiry;
    state_t state_d;
    logic   enter_walk;
    logic   walk_pending_d;
    heads_t next_heads;

    always_comb begin
        // An expiry arriving while the start pulse is out is stale.
        qual_expiry    = expired && !start_q;
        state_d        = state_q;
        enter_walk     = 1'b0;
        walk_pending_d = walk_pending_q;
        next_heads     = heads_for(state_q);

        if (qual_expiry) begin
            case (state_q)
                // The sensor only matters at the end of a first green.
                MAIN_G1: state_d = sensor_s ? MAIN_GX : MAIN_G2;
                MAIN_G2: state_d = MAIN_Y;
                MAIN_GX: state_d = MAIN_Y;
                MAIN_Y:  state_d = walk_pending_q ? WALK : SIDE_G;
                WALK:    state_d = SIDE_G;
                SIDE_G:  state_d = sensor_s ? SIDE_GX : SIDE_Y;
                SIDE_GX: state_d = SIDE_Y;
                SIDE_Y:  state_d = MAIN_G1;
                default: state_d = MAIN_G1;
            endcase
        end

        enter_walk = qual_expiry && (state_d == WALK);

        // A request coinciding with the walk entry is the one being
        // served, so the clear takes priority over the set.
        if (enter_walk) begin
            walk_pending_d = 1'b0;
        end else if (walk_s) begin
            walk_pending_d = 1'b1;
        end

        next_heads = heads_for(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // start stays high through reset so the first cycle after
            // release restarts the timer with the base interval.
            state_q        <= MAIN_G1;
            start_q        <= 1'b1;
            sel_q          <= BASE_SELECT;
            main_q         <= LAMP_GRN;
            side_q         <= LAMP_RED;
            walk_lamp_q    <= 1'b0;
            walk_pending_q <= 1'b0;
        end else begin
            walk_pending_q <= walk_pending_d;
            start_q        <= qual_expiry;
            if (qual_expiry) begin
                state_q     <= state_d;
                sel_q       <= next_heads.sel;
                main_q      <= next_heads.main_lamp;
                side_q      <= next_heads.side_lamp;
                walk_lamp_q <= next_heads.walk;
            end
        end
    end

    // -----------------------------------------------------------------
    // Outputs: all straight from registers
    // -----------------------------------------------------------------
    assign start_timer  = start_q;
    assign interval_sel = sel_q;
    assign main_lights  = main_q;
    assign side_lights  = side_q;
    assign walk_lamp    = walk_lamp_q;
    assign state_dbg    = state_q;

    // -----------------------------------------------------------------
    // Safety properties
    // -----------------------------------------------------------------
    a_lamps_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot(main_lights) && $onehot(side_lights));

    a_no_conflict : assert property (@(posedge clk) disable iff (reset)
        (main_lights == LAMP_RED) || (side_lights == LAMP_RED));

    a_sel_legal : assert property (@(posedge clk) disable iff (reset)
        interval_sel != 2'b11);

    a_start_single : assert property (@(posedge clk) disable iff (reset)
        start_timer |=> !start_timer);

endmodule

// File: tb/tb_traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_fsm
//
// Directed bench for traffic_light_fsm. A timer model answers every
// start_timer with an expired pulse after a programmable delay (or holds
// expired high in zero-interval mode). Stimulus pushes the expected
// sequence of state entries; a monitor pops one entry per start_timer
// pulse and compares state, interval, lamps and walk lamp, plus the
// spacing between start pulses.
// ---------------------------------------------------------------------------
module tb_traffic_light_fsm;

    // ------------------------------------------------------------ clock/reset
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       expired = 1'b0;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_lamp;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    traffic_light_fsm #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .walk_request (walk_request),
        .expired      (expired),
        .start_timer  (start_timer),
        .interval_sel (interval_sel),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk_lamp    (walk_lamp),
        .state_dbg    (state_dbg)
    );

    // ------------------------------------------------------------ scoreboard
    // Entry layout: {state[2:0], sel[1:0], main[2:0], side[2:0], walk}
    logic [11:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    int exp_delay = 5;   // expired arrives this many cycles after start
    bit zero_mode = 1'b0;
    int exp_gap = 6;     // required cycles between consecutive start pulses
    int cyc = 0;
    int last_start = 0;
    bit have_last = 1'b0;
    int tmr_cnt = 0;

    // Hand-written table of what each state must present on entry.
    function automatic logic [11:0] visit(input int st);
        logic [11:0] v;
        case (st)
            0:       v = {3'd0, 2'b00, 3'b001, 3'b100, 1'b0};
            1:       v = {3'd1, 2'b00, 3'b001, 3'b100, 1'b0};
            2:       v = {3'd2, 2'b01, 3'b001, 3'b100, 1'b0};
            3:       v = {3'd3, 2'b10, 3'b010, 3'b100, 1'b0};
            4:       v = {3'd4, 2'b01, 3'b100, 3'b100, 1'b1};
            5:       v = {3'd5, 2'b00, 3'b100, 3'b001, 1'b0};
            6:       v = {3'd6, 2'b01, 3'b100, 3'b001, 1'b0};
            default: v = {3'd7, 2'b10, 3'b100, 3'b010, 1'b0};
        endcase
        return v;
    endfunction

    task automatic push_seq(input int seq[$]);
        foreach (seq[i]) exp_q.push_back(visit(seq[i]));
    endtask

    // ------------------------------------------------------------ timer model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            expired = 1'b0;
            if (zero_mode) begin
                expired = 1'b1;
            end else if (start_timer) begin
                tmr_cnt = exp_delay;
            end else if (tmr_cnt > 0) begin
                tmr_cnt = tmr_cnt - 1;
                if (tmr_cnt == 0) expired = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        logic [11:0] got;
        logic [11:0] want;
        cyc = cyc + 1;
        if (reset) begin
            have_last = 1'b0;
        end else begin
            vectors = vectors + 1;
            if (!($onehot(main_lights) && $onehot(side_lights) &&
                  (main_lights == 3'b100 || side_lights == 3'b100))) begin
                miscompares = miscompares + 1;
                $display("FAIL lamp_safety cyc=%0d main=%b side=%b", cyc, main_lights, side_lights);
            end
            if (start_timer) begin
                got = {state_dbg, interval_sel, main_lights, side_lights, walk_lamp};
                vectors = vectors + 1;
                if (exp_q.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL unexpected_start cyc=%0d got=%h required=none", cyc, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        miscompares = miscompares + 1;
                        $display("FAIL entry cyc=%0d got st=%0d sel=%b m=%b s=%b w=%b required st=%0d sel=%b m=%b s=%b w=%b",
                                 cyc, got[11:9], got[8:7], got[6:4], got[3:1], got[0],
                                 want[11:9], want[8:7], want[6:4], want[3:1], want[0]);
                    end
                    if (have_last) begin
                        vectors = vectors + 1;
                        if (cyc - last_start != exp_gap) begin
                            miscompares = miscompares + 1;
                            $display("FAIL start_gap cyc=%0d got=%0d required=%0d", cyc, cyc - last_start, exp_gap);
                        end
                    end
                end
                last_start = cyc;
                have_last  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ driver tasks
    // All driver tasks are entered and left at posedge + 1.
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n = n + 1;
        end
        if (exp_q.size() != 0) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL drain_timeout got=%0d entries left required=0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sensor       = 1'b0;
        walk_request = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        logic [12:0] got;
        logic [12:0] want;
        want = {3'd0, 2'b00, 3'b001, 3'b100, 1'b0, 1'b1};
        got  = {state_dbg, interval_sel, main_lights, side_lights, walk_lamp, start_timer};
        vectors = vectors + 1;
        if (got !== want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got=%b required=%b", name, got, want);
        end
    endtask

    task automatic pulse(input int which);
        if (which == 0) sensor = 1'b1; else walk_request = 1'b1;
        @(posedge clk);
        #1;
        sensor       = 1'b0;
        walk_request = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    // After a release at posedge+1 the current cycle is cycle 0, the
    // first start cycle; with delay 5 each state lasts 6 cycles.
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_values");
        @(posedge clk);
        #1;

        // Plain cycle, no sensor, no walk.
        exp_gap = 6;
        push_seq('{0, 1, 3, 5, 7, 0});
        reset = 1'b0;
        wait_drain(200);
        do_reset();

        // Sensor held high: both extensions taken.
        sensor = 1'b1;
        push_seq('{0, 2, 3, 5, 6, 7, 0});
        reset = 1'b0;
        wait_drain(200);
        do_reset();

        // One-cycle sensor pulse in cycle 1, gone by the expiry in cycle 5.
        push_seq('{0, 1, 3});
        reset = 1'b0;
        @(posedge clk);
        #1;
        pulse(0);
        wait_drain(200);
        do_reset();

        // Sensor raised in cycle 3 only: synchronised value is high in
        // cycle 5, exactly the MAIN_G1 expiry cycle.
        push_seq('{0, 2, 3, 5, 7});
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulse(0);
        wait_drain(200);
        do_reset();

        // Walk request during SIDE_Y (cycle 25) is served at the next
        // MAIN_Y. A second request raised in cycle 45 reaches the
        // synchronised side in cycle 47, the MAIN_Y -> WALK cycle, and
        // must not produce a second walk.
        push_seq('{0, 1, 3, 5, 7, 0, 1, 3, 4, 5, 7, 0, 1, 3, 5});
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        pulse(1);
        repeat (19) @(posedge clk);
        #1;
        pulse(1);
        wait_drain(300);
        do_reset();

        // Zero interval: expired held high, including start cycles.
        zero_mode = 1'b1;
        exp_gap   = 2;
        push_seq('{0, 1, 3, 5, 7, 0, 1});
        reset = 1'b0;
        wait_drain(100);
        do_reset();
        zero_mode = 1'b0;
        exp_gap   = 6;
        do_reset();

        // Reset during MAIN_Y with a walk pending.
        push_seq('{0, 1, 3});
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pulse(1);
        wait_drain(200);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset_values");
        @(posedge clk);
        #1;
        push_seq('{0, 1, 3, 5});
        reset = 1'b0;
        wait_drain(200);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ------------------------------------------------------------ watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

endmodule
